// File: rtl/helios_core_dispatcher_pkg.sv
// Shared types and constants for the Helios multi-core dispatcher.
// Holds the dispatch state encoding, the byte width and an index-width helper.
package helios_core_dispatcher_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        DISP_SELECT = 1'b0,
        DISP_STREAM = 1'b1
    } disp_state_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/helios_index_fifo.sv
// Synchronous FIFO of core indices recording the order in which frames were dispatched.
// A push is refused when full, even if a pop happens in the same cycle.
module helios_index_fifo
    import helios_core_dispatcher_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int              AW   = idx_width(DEPTH);
    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/helios_core_dispatcher.sv
// Deals whole syndrome frames round-robin over the enabled decoder cores and
// returns their result frames to the host in dispatch order.
module helios_core_dispatcher
    import helios_core_dispatcher_pkg::*;
#(
    parameter int CORE_COUNT   = 2,
    parameter int FRAME_BYTES  = 4,
    parameter int RESULT_BYTES = 2,
    parameter int ORDER_DEPTH  = 4,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CORE_COUNT-1:0]                core_enable,
    input  logic [BYTE_W-1:0]                    input_data,
    input  logic                                 input_valid,
    output logic                                 input_ready,
    output logic [BYTE_W-1:0]                    output_data,
    output logic                                 output_valid,
    input  logic                                 output_ready,
    output logic [CORE_COUNT-1:0][BYTE_W-1:0]    core_input_data,
    output logic [CORE_COUNT-1:0]                core_input_valid,
    input  logic [CORE_COUNT-1:0]                core_input_ready,
    input  logic [CORE_COUNT-1:0][BYTE_W-1:0]    core_output_data,
    input  logic [CORE_COUNT-1:0]                core_output_valid,
    output logic [CORE_COUNT-1:0]                core_output_ready,
    output logic [STAT_WIDTH-1:0]                frames_in,
    output logic [STAT_WIDTH-1:0]                frames_out,
    output logic [$clog2(ORDER_DEPTH):0]         in_flight,
    output disp_state_t                          dbg_disp_state
);

    // Byte streams: a byte moves on a rising clk edge where its valid and ready
    // are both high; valid never waits on ready, and ready may depend on valid.

    localparam int                PTR_W     = idx_width(CORE_COUNT);
    localparam int                DCNT_W    = idx_width(FRAME_BYTES);
    localparam int                CCNT_W    = idx_width(RESULT_BYTES);
    localparam logic [PTR_W-1:0]  LAST_CORE = PTR_W'(CORE_COUNT - 1);
    localparam logic [DCNT_W-1:0] LAST_IN   = DCNT_W'(FRAME_BYTES - 1);
    localparam logic [CCNT_W-1:0] LAST_OUT  = CCNT_W'(RESULT_BYTES - 1);

    disp_state_t             r_disp_state;
    disp_state_t             w_disp_state_nxt;
    logic [PTR_W-1:0]        r_disp_ptr;
    logic [PTR_W-1:0]        w_disp_ptr_nxt;
    logic [PTR_W-1:0]        w_ptr_inc;
    logic [DCNT_W-1:0]       r_disp_cnt;
    logic [CCNT_W-1:0]       r_col_cnt;
    logic [STAT_WIDTH-1:0]   r_frames_in;
    logic [STAT_WIDTH-1:0]   r_frames_out;
    logic [PTR_W-1:0]        w_col_ptr;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_in_accept;
    logic                    w_in_last;
    logic                    w_push;
    logic                    w_out_accept;
    logic                    w_pop;

    assign w_ptr_inc       = (r_disp_ptr == LAST_CORE) ? '0 : r_disp_ptr + PTR_W'(1);
    assign w_push          = w_in_accept & (r_disp_cnt == '0);
    assign w_in_last       = w_in_accept & (r_disp_cnt == LAST_IN);
    assign w_out_accept    = output_valid & output_ready;
    assign w_pop           = w_out_accept & (r_col_cnt == LAST_OUT);
    assign core_input_data = {CORE_COUNT{input_data}};
    assign frames_in       = r_frames_in;
    assign frames_out      = r_frames_out;
    assign dbg_disp_state  = r_disp_state;

    always_comb begin
        w_disp_state_nxt = r_disp_state;
        w_disp_ptr_nxt   = r_disp_ptr;
        input_ready      = 1'b0;
        core_input_valid = '0;
        w_in_accept      = 1'b0;
        case (r_disp_state)
            DISP_SELECT: begin
                // A disabled core costs one cycle; with none enabled this spins forever.
                if (!core_enable[r_disp_ptr]) begin
                    w_disp_ptr_nxt = w_ptr_inc;
                end else if (!w_fifo_full) begin
                    w_disp_state_nxt = DISP_STREAM;
                end
            end
            DISP_STREAM: begin
                core_input_valid[r_disp_ptr] = input_valid;
                input_ready                  = core_input_ready[r_disp_ptr];
                w_in_accept                  = input_valid & core_input_ready[r_disp_ptr];
                if (w_in_accept && (r_disp_cnt == LAST_IN)) begin
                    w_disp_state_nxt = DISP_SELECT;
                    w_disp_ptr_nxt   = w_ptr_inc;
                end
            end
            default: w_disp_state_nxt = DISP_SELECT;
        endcase
    end

    always_comb begin
        output_valid      = 1'b0;
        output_data       = '0;
        core_output_ready = '0;
        if (!w_fifo_empty) begin
            output_valid                 = core_output_valid[w_col_ptr];
            output_data                  = core_output_data[w_col_ptr];
            core_output_ready[w_col_ptr] = output_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp_state <= DISP_SELECT;
            r_disp_ptr   <= '0;
            r_disp_cnt   <= '0;
            r_col_cnt    <= '0;
            r_frames_in  <= '0;
            r_frames_out <= '0;
        end else begin
            r_disp_state <= w_disp_state_nxt;
            r_disp_ptr   <= w_disp_ptr_nxt;
            if (w_in_accept) begin
                r_disp_cnt <= w_in_last ? '0 : r_disp_cnt + DCNT_W'(1);
            end
            if (w_in_last) begin
                r_frames_in <= r_frames_in + STAT_WIDTH'(1);
            end
            if (w_out_accept) begin
                r_col_cnt <= w_pop ? '0 : r_col_cnt + CCNT_W'(1);
            end
            if (w_pop) begin
                r_frames_out <= r_frames_out + STAT_WIDTH'(1);
            end
        end
    end

    helios_index_fifo #(
        .WIDTH (PTR_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_data (r_disp_ptr),
        .i_pop       (w_pop),
        .o_head      (w_col_ptr),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (in_flight)
    );

endmodule

// File: tb/tb_helios_core_dispatcher.sv
// Bench for helios_core_dispatcher: behavioural host and core models, a
// scoreboard of expected result bytes, scenario tables and corner sequences.
module tb_helios_core_dispatcher;
    import helios_core_dispatcher_pkg::*;

    localparam int CC = 2;
    localparam int FB = 4;
    localparam int RB = 2;
    localparam int OD = 4;
    localparam int SW = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [CC-1:0]          core_enable;
    logic [7:0]             input_data;
    logic                   input_valid;
    logic                   input_ready;
    logic [7:0]             output_data;
    logic                   output_valid;
    logic                   output_ready;
    logic [CC-1:0][7:0]     core_input_data;
    logic [CC-1:0]          core_input_valid;
    logic [CC-1:0]          core_input_ready;
    logic [CC-1:0][7:0]     core_output_data;
    logic [CC-1:0]          core_output_valid;
    logic [CC-1:0]          core_output_ready;
    logic [SW-1:0]          frames_in;
    logic [SW-1:0]          frames_out;
    logic [$clog2(OD):0]    in_flight;
    disp_state_t            dbg_disp_state;

    helios_core_dispatcher #(
        .CORE_COUNT   (CC),
        .FRAME_BYTES  (FB),
        .RESULT_BYTES (RB),
        .ORDER_DEPTH  (OD),
        .STAT_WIDTH   (SW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .core_enable       (core_enable),
        .input_data        (input_data),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .output_data       (output_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .core_input_data   (core_input_data),
        .core_input_valid  (core_input_valid),
        .core_input_ready  (core_input_ready),
        .core_output_data  (core_output_data),
        .core_output_valid (core_output_valid),
        .core_output_ready (core_output_ready),
        .frames_in         (frames_in),
        .frames_out        (frames_out),
        .in_flight         (in_flight),
        .dbg_disp_state    (dbg_disp_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model state ----------------
    logic [7:0]    host_q[$];
    logic [7:0]    hf_q[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    cin_q[CC][$];
    logic [7:0]    cres_q[CC][$];
    int            first_core_log[$];
    logic [SW-1:0] m_frames_in;
    logic [SW-1:0] m_frames_out;
    int            m_inflight;
    int            ref_ptr;
    int            out_bytes;
    bit            rnd;
    bit            host_out_en;
    bit [CC-1:0]   hold;
    bit [CC-1:0]   valid_seen;
    bit            host_acc;
    bit            out_acc;
    bit [CC-1:0]   core_acc;
    bit [CC-1:0]   cout_acc;
    int            last_cycles;
    int            n_checks;
    int            n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A core's result is a pure function of its frame and its own index.
    function automatic logic [7:0] res_byte(input int core, input logic [7:0] sum, input int j);
        return sum + 8'(j * 17) + 8'(core * 64);
    endfunction

    function automatic logic [7:0] sum_bytes(input logic [7:0] q[$]);
        logic [7:0] s = 8'h00;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    function automatic int next_enabled(input int from);
        for (int k = 0; k < CC; k++) begin
            if (core_enable[(from + k) % CC]) return (from + k) % CC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        host_q.delete();
        hf_q.delete();
        exp_q.delete();
        first_core_log.delete();
        for (int c = 0; c < CC; c++) begin
            cin_q[c].delete();
            cres_q[c].delete();
        end
        m_frames_in       = '0;
        m_frames_out      = '0;
        m_inflight        = 0;
        ref_ptr           = 0;
        out_bytes         = 0;
        valid_seen        = '0;
        host_acc          = 1'b0;
        out_acc           = 1'b0;
        core_acc          = '0;
        cout_acc          = '0;
        input_valid       = 1'b0;
        input_data        = 8'h00;
        output_ready      = 1'b0;
        core_input_ready  = '0;
        core_output_valid = '0;
        core_output_data  = '0;
    endtask

    // ---------------- sampling + reference model (negedge) ----------------
    task automatic sample_and_update();
        logic [7:0] s;
        int         ec;
        chk("frames_in", 32'(frames_in), 32'(m_frames_in));
        chk("frames_out", 32'(frames_out), 32'(m_frames_out));
        chk("in_flight", 32'(in_flight), 32'(m_inflight));
        host_acc   = input_valid & input_ready;
        core_acc   = core_input_valid & core_input_ready;
        out_acc    = output_valid & output_ready;
        cout_acc   = core_output_valid & core_output_ready;
        valid_seen = valid_seen | core_input_valid;
        if (host_acc || core_acc != '0)
            chk("core_byte_route", $countones(core_acc), host_acc ? 1 : 0);
        if (host_acc) begin
            hf_q.push_back(host_q.pop_front());
            if (hf_q.size() == 1) begin
                m_inflight++;
                ec = -1;
                for (int c = 0; c < CC; c++) if (core_acc[c]) ec = c;
                first_core_log.push_back(ec);
            end
            if (hf_q.size() == FB) begin
                ec = next_enabled(ref_ptr);
                s  = sum_bytes(hf_q);
                for (int j = 0; j < RB; j++) exp_q.push_back(res_byte(ec, s, j));
                ref_ptr = (ec + 1) % CC;
                m_frames_in++;
                hf_q.delete();
            end
        end
        for (int c = 0; c < CC; c++) begin
            if (core_acc[c]) begin
                cin_q[c].push_back(core_input_data[c]);
                if (cin_q[c].size() == FB) begin
                    s = sum_bytes(cin_q[c]);
                    for (int j = 0; j < RB; j++) cres_q[c].push_back(res_byte(c, s, j));
                    cin_q[c].delete();
                end
            end
        end
        if (out_acc) begin
            if (exp_q.size() == 0) chk("unexpected_out", 32'(output_data), 32'hFFFF_FFFF);
            else chk("out_byte", 32'(output_data), 32'(exp_q.pop_front()));
            out_bytes++;
            if (out_bytes == RB) begin
                out_bytes = 0;
                m_frames_out++;
                m_inflight--;
            end
        end
        if (out_acc || cout_acc != '0)
            chk("out_route", $countones(cout_acc), out_acc ? 1 : 0);
        for (int c = 0; c < CC; c++) begin
            if (cout_acc[c] && cres_q[c].size() > 0) void'(cres_q[c].pop_front());
        end
    endtask

    // ---------------- drivers (posedge + 1) ----------------
    task automatic drive();
        if (!(input_valid && !host_acc && host_q.size() > 0))
            input_valid = (host_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        input_data = (host_q.size() > 0) ? host_q[0] : 8'h00;
        for (int c = 0; c < CC; c++) begin
            core_input_ready[c] = !rnd || ($urandom_range(0, 2) != 0);
            if (!(core_output_valid[c] && !cout_acc[c] && cres_q[c].size() > 0))
                core_output_valid[c] = (cres_q[c].size() > 0) && !hold[c] &&
                                       (!rnd || $urandom_range(0, 1) == 1);
            core_output_data[c] = (cres_q[c].size() > 0) ? cres_q[c][0] : 8'h00;
        end
        output_ready = host_out_en && (!rnd || $urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        @(negedge clk);
        sample_and_update();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_frames(input int n, input int base);
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < FB; k++) begin
                if (base < 0) host_q.push_back(8'($urandom_range(0, 255)));
                else host_q.push_back(8'(base + f * FB + k));
            end
        end
    endtask

    task automatic run_until_in(input int n, input int budget);
        last_cycles = 0;
        while (int'(m_frames_in) < n && last_cycles < budget) begin
            step();
            last_cycles++;
        end
        if (int'(m_frames_in) < n) chk("timeout_frames_in", 32'(m_frames_in), 32'(n));
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while ((exp_q.size() > 0 || m_inflight > 0) && cyc < budget) begin
            step();
            cyc++;
        end
        if (exp_q.size() > 0 || m_inflight > 0) chk("timeout_drain", 32'(exp_q.size()), 0);
        repeat (2) step();
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        logic [CC-1:0] en;
        int            nfr;
        logic [7:0]    exp_cores;   // bit f = core that receives frame f
        int            exp_cycles;  // cycles from reset release to last byte
    } vec_t;

    vec_t vecs[3];

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rnd         = 1'b0;
        hold        = '0;
        host_out_en = 1'b1;
        core_enable = 2'b11;
        reset       = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_input_ready", 32'(input_ready), 0);
        chk("rst_output_valid", 32'(output_valid), 0);
        chk("rst_output_data", 32'(output_data), 0);
        chk("rst_core_in_valid", 32'(core_input_valid), 0);
        chk("rst_core_out_ready", 32'(core_output_ready), 0);
        chk("rst_frames_in", 32'(frames_in), 0);
        chk("rst_frames_out", 32'(frames_out), 0);
        chk("rst_in_flight", 32'(in_flight), 0);
        chk("rst_state", 32'(dbg_disp_state), 32'(DISP_SELECT));

        // Table: round-robin and disabled-core skipping, deterministic flow
        vecs[0] = '{en: 2'b11, nfr: 4, exp_cores: 8'b0000_1010, exp_cycles: 20};
        vecs[1] = '{en: 2'b10, nfr: 3, exp_cores: 8'b0000_0111, exp_cycles: 18};
        vecs[2] = '{en: 2'b01, nfr: 3, exp_cores: 8'b0000_0000, exp_cycles: 17};
        for (int v = 0; v < 3; v++) begin
            core_enable = vecs[v].en;
            do_reset();
            send_frames(vecs[v].nfr, 8'h10);
            drive();
            run_until_in(vecs[v].nfr, 200);
            chk("tbl_cycles", 32'(last_cycles), 32'(vecs[v].exp_cycles));
            for (int f = 0; f < vecs[v].nfr; f++) begin
                if (first_core_log.size() > f)
                    chk("tbl_core", 32'(first_core_log[f]), 32'(vecs[v].exp_cores[f]));
                else
                    chk("tbl_core_missing", 32'(first_core_log.size()), 32'(f + 1));
            end
            chk("tbl_valid_disabled", 32'(valid_seen & ~vecs[v].en), 0);
            drain(200);
            chk("tbl_frames_in", 32'(frames_in), 32'(vecs[v].nfr));
            chk("tbl_frames_out", 32'(frames_out), 32'(vecs[v].nfr));
        end

        // In-order return: core 1 finishes long before core 0
        core_enable = 2'b11;
        hold        = 2'b01;
        do_reset();
        send_frames(2, -1);
        drive();
        run_until_in(2, 100);
        repeat (30) step();
        chk("order_head_blocks", 32'(output_valid), 0);
        chk("order_core_ready", 32'(core_output_ready), 32'(2'b01));
        chk("order_frames_out0", 32'(frames_out), 0);
        hold = '0;
        drain(100);
        chk("order_frames_out", 32'(frames_out), 2);

        // FIFO full: results held, five frames offered
        hold = 2'b11;
        do_reset();
        send_frames(5, -1);
        drive();
        repeat (40) step();
        chk("full_in_flight", 32'(in_flight), 4);
        chk("full_frames_in", 32'(frames_in), 4);
        chk("full_input_ready", 32'(input_ready), 0);
        chk("full_state", 32'(dbg_disp_state), 32'(DISP_SELECT));
        hold = 2'b10;
        run_until_in(5, 60);
        step();
        chk("full_reopen_frames_in", 32'(frames_in), 5);
        hold = '0;
        drain(200);
        chk("full_frames_out", 32'(frames_out), 5);

        // All cores disabled: no dispatch at all
        core_enable = 2'b00;
        do_reset();
        send_frames(1, -1);
        drive();
        for (int i = 0; i < 50; i++) begin
            step();
            chk("dis_input_ready", 32'(input_ready), 0);
        end
        chk("dis_no_push", 32'(in_flight), 0);
        chk("dis_core_valid", 32'(core_input_valid), 0);

        // Reset mid-frame
        core_enable = 2'b11;
        hold        = 2'b10;
        host_out_en = 1'b0;
        do_reset();
        send_frames(2, -1);
        drive();
        last_cycles = 0;
        while (!(m_frames_in == 1 && hf_q.size() == 2) && last_cycles < 50) begin
            step();
            last_cycles++;
        end
        chk("mid_reached", 32'(hf_q.size()), 2);
        chk("mid_pre_ready", 32'(input_ready), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_input_ready", 32'(input_ready), 0);
        chk("mid_output_valid", 32'(output_valid), 0);
        chk("mid_output_data", 32'(output_data), 0);
        chk("mid_core_in_valid", 32'(core_input_valid), 0);
        chk("mid_core_out_ready", 32'(core_output_ready), 0);
        chk("mid_frames_in", 32'(frames_in), 0);
        chk("mid_in_flight", 32'(in_flight), 0);
        chk("mid_state", 32'(dbg_disp_state), 32'(DISP_SELECT));
        model_reset();
        hold        = '0;
        host_out_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send_frames(1, -1);
        drive();
        run_until_in(1, 50);
        if (first_core_log.size() > 0) chk("mid_restart_core", 32'(first_core_log[0]), 0);
        else chk("mid_restart_missing", 0, 1);
        drain(100);
        chk("mid_frames_out", 32'(frames_out), 1);

        // Randomized traffic against the reference model
        rnd = 1'b1;
        for (int seg = 0; seg < 3; seg++) begin
            core_enable = (seg == 0) ? 2'b11 : (seg == 1) ? 2'b10 : 2'b01;
            hold        = '0;
            do_reset();
            send_frames(20, -1);
            drive();
            run_until_in(20, 3000);
            drain(3000);
            chk("rand_frames_in", 32'(frames_in), 20);
            chk("rand_frames_out", 32'(frames_out), 20);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/helios_core_dispatcher.md
# helios_core_dispatcher

Multi-core front end for scaling a single FPGA from one decoder core to `CORE_COUNT` cores. Each core is a decoding-graph/unified-controller pair with an 8-bit valid/ready byte stream on both sides. The block sits between the host byte stream and those cores. It deals whole syndrome frames round-robin over the enabled cores and returns the per-frame results to the host in dispatch order, using an order FIFO of core indices. It also exports frame counters for throughput monitoring.

## Interface
- `CORE_COUNT`, 2: number of decoder cores, at least 1.
- `FRAME_BYTES`, 4: input bytes per syndrome frame, at least 1.
- `RESULT_BYTES`, 2: output bytes per result frame, at least 1.
- `ORDER_DEPTH`, 4: order-FIFO entries, i.e. the maximum number of frames in flight; power of 2.
- `STAT_WIDTH`, 16: width of the frame counters.
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-low.
- `core_enable`  in  CORE_COUNT  per-core enable mask, quasi-static.
- `input_data`  in  8  host byte.
- `input_valid`  in  1  host byte valid.
- `input_ready`  out  1  host byte accepted.
- `output_data`  out  8  result byte.
- `output_valid`  out  1  result byte valid.
- `output_ready`  in  1  host sink ready.
- `core_input_data`  out  8×CORE_COUNT  byte to each core, broadcast.
- `core_input_valid`  out  CORE_COUNT  per-core valid.
- `core_input_ready`  in  CORE_COUNT  per-core ready.
- `core_output_data`  in  8×CORE_COUNT  per-core result byte.
- `core_output_valid`  in  CORE_COUNT  per-core result valid.
- `core_output_ready`  out  CORE_COUNT  per-core result ready.
- `frames_in`  out  STAT_WIDTH  completed dispatched frames.
- `frames_out`  out  STAT_WIDTH  completed returned frames.
- `in_flight`  out  log2(ORDER_DEPTH)+1  current order-FIFO occupancy.

## Operation
- **Dispatch registers.** `disp_ptr` (core index), `disp_cnt` (0..FRAME_BYTES-1), `disp_state` ∈ {SELECT, STREAM}.
- **SELECT state.**
  - If `core_enable[disp_ptr]` = 0: increment `disp_ptr` modulo CORE_COUNT, one step per cycle.
  - If all cores are disabled, stay in SELECT with `input_ready` = 0.
  - If the pointed core is enabled and the order FIFO is not full: go to STREAM. SELECT therefore costs at least one bubble cycle per frame.
- **STREAM state.**
  - `core_input_valid[disp_ptr] = input_valid`; all other valids are 0.
  - `input_ready = core_input_ready[disp_ptr]`. Both are combinational.
  - On the first accepted byte (`disp_cnt` = 0), push `disp_ptr` into the order FIFO.
  - On the byte with `disp_cnt` = FRAME_BYTES-1: clear `disp_cnt`, increment `frames_in`, advance `disp_ptr` modulo CORE_COUNT, return to SELECT.
  - `core_enable` is ignored mid-frame.
- **Collect registers.** `col_cnt` (0..RESULT_BYTES-1); `col_ptr` is the order-FIFO head.
- **Collect path (combinational, FIFO non-empty).**
  - `output_data = core_output_data[col_ptr]`.
  - `output_valid = core_output_valid[col_ptr]`.
  - `core_output_ready[col_ptr] = output_ready`.
  - When the FIFO is empty: `output_valid` = 0 and all `core_output_ready` = 0.
- **Collect frame end.** On the accepted byte with `col_cnt` = RESULT_BYTES-1: pop the FIFO, increment `frames_out`, clear `col_cnt`.
- **Order FIFO.** Push is gated by not-full; a simultaneous pop does not free a slot in the same cycle. Push and pop in the same cycle when not full leaves occupancy unchanged. `in_flight` equals the occupancy.
- **Counters.** `frames_in` and `frames_out` wrap modulo 2^STAT_WIDTH with no saturation.

## Timing
- **Reset (asynchronous assert).** Immediately: `disp_state` = SELECT, `disp_ptr`, `disp_cnt`, `col_cnt`, `frames_in`, `frames_out` and FIFO pointers = 0, `in_flight` = 0. All valid/ready outputs = 0, `output_data` = 0. Deassertion is synchronised externally.
- **Data path latency.** Zero-cycle muxes in both directions.
- **Frame-start bubble.** One SELECT cycle at every frame start, plus one cycle per disabled core skipped.
- **Frame counters.** `frames_in` and `frames_out` update the cycle after the last byte handshake.
- **Reset mid-frame.** Partial frames are discarded; the cores must be reset together with this block.

## Structure
- **Shared package.** Dispatch state enum {SELECT, STREAM} and byte width constant (8) go in the shared parameters package.
- **Sub-module.** One sub-module, `helios_index_fifo`: synchronous FIFO, width $clog2(CORE_COUNT) (minimum 1), depth ORDER_DEPTH, with full/empty/count outputs.
- **Wiring.** The top level instantiates CORE_COUNT core pairs outside this block.

## Test plan
- **Basic round-robin.** CORE_COUNT = 2, all enabled, cores always ready, 4 frames of bytes 0x10..0x1F → frames go to cores 0,1,0,1; `frames_in` = 4.
- **In-order return.** Core 1 returns its result 20 cycles before core 0 → host still receives core 0's 2 bytes first, then core 1's; `frames_out` = 2.
- **Disabled core.** `core_enable` = 2'b10 → all frames go to core 1; core 0 valid stays 0; one extra SELECT cycle is seen per skip.
- **FIFO full.** ORDER_DEPTH = 4, all cores stalled on output, 5 frames offered → 4 accepted, `in_flight` = 4, `input_ready` = 0 at frame 5; draining one result reopens dispatch.
- **All cores disabled.** `core_enable` = 0 → `input_ready` stays 0 for 50 cycles; no FIFO push.
- **Reset mid-frame.** Assert `reset` after byte 2 of a frame → all outputs return to 0 in the same cycle; after release, the next frame starts at core 0.
